// File: rtl/riscv_icache_refill.sv
// Instruction-cache refill controller: tag/valid lookup for the fetch block and, on a
// misaligned fetch, its successor block; misses fetch 128-bit blocks from memory.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | lookup of block A (and block B when misaligned), fence clear
// REFILL_A | waiting on memory for block A at index
// REFILL_B | waiting on memory for block B at index_missallign
module riscv_icache_refill #(
  parameter int INDEX       = 12,
  parameter int DWIDTH      = 128,
  parameter int AWIDTH      = 64,
  parameter int BYTE_OFFSET = 4,
  parameter int CACHE_DEPTH = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic              fence_i,
  output logic              stall,
  output logic              mem_req,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DWIDTH-1:0] mem_data,
  output logic              wren,
  output logic              index_sel,
  output logic [INDEX-1:0]  index,
  output logic [INDEX-1:0]  index_missallign,
  output logic [DWIDTH-1:0] data_in
);

  localparam int TAG = AWIDTH - INDEX - BYTE_OFFSET;
  localparam logic [AWIDTH-1:0]      BLK_STEP  = AWIDTH'(1) << BYTE_OFFSET;
  localparam logic [INDEX-1:0]       LAST_IDX  = INDEX'(CACHE_DEPTH - 1);
  localparam logic [BYTE_OFFSET-1:0] MIS_LIMIT = BYTE_OFFSET'(12);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REFILL_A = 2'd1,
    REFILL_B = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [TAG-1:0]         tag_q [CACHE_DEPTH];
  logic [CACHE_DEPTH-1:0] valid_q;
  logic                   fence_pending_q, fence_pending_d;

  logic [AWIDTH-1:0] blk_a_q, blk_a_d;
  logic [AWIDTH-1:0] blk_b_q, blk_b_d;
  logic [INDEX-1:0]  idx_b_q, idx_b_d;
  logic              mis_q, mis_d;

  logic [AWIDTH-1:0] blk_a, blk_b;
  logic [INDEX-1:0]  idx_a, idx_b;
  logic [TAG-1:0]    tag_a, tag_b;
  logic              misaligned;
  logic              hit_a, hit_b, hit_b_lat;

  logic              latch_en;
  logic              clr_all;
  logic              wren_c;
  logic              tag_we;
  logic [INDEX-1:0]  wr_idx;
  logic [TAG-1:0]    wr_tag;

  // Block B is the next block in the address space; its index wraps independently.
  always_comb begin
    blk_a      = {cpu_addr[AWIDTH-1:BYTE_OFFSET], {BYTE_OFFSET{1'b0}}};
    blk_b      = blk_a + BLK_STEP;
    idx_a      = cpu_addr[BYTE_OFFSET+INDEX-1:BYTE_OFFSET];
    idx_b      = (idx_a == LAST_IDX) ? '0 : idx_a + INDEX'(1);
    tag_a      = cpu_addr[AWIDTH-1:BYTE_OFFSET+INDEX];
    tag_b      = blk_b[AWIDTH-1:BYTE_OFFSET+INDEX];
    misaligned = cpu_addr[BYTE_OFFSET-1:0] > MIS_LIMIT;
    hit_a      = valid_q[idx_a] && (tag_q[idx_a] == tag_a);
    hit_b      = valid_q[idx_b] && (tag_q[idx_b] == tag_b);
    hit_b_lat  = valid_q[idx_b_q] && (tag_q[idx_b_q] == blk_b_q[AWIDTH-1:BYTE_OFFSET+INDEX]);
  end

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    wren_c    = 1'b0;
    index_sel = 1'b0;
    latch_en  = 1'b0;
    clr_all   = 1'b0;
    wr_idx    = '0;
    wr_tag    = '0;
    case (state_q)
      IDLE: begin
        if (fence_pending_q) begin
          stall   = 1'b1;
          clr_all = 1'b1;
        end else if (cpu_req) begin
          if (!hit_a) begin
            stall    = 1'b1;
            latch_en = 1'b1;
            state_d  = REFILL_A;
          end else if (misaligned && !hit_b) begin
            stall    = 1'b1;
            latch_en = 1'b1;
            state_d  = REFILL_B;
          end
        end
      end
      REFILL_A: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = blk_a_q;
        wr_idx   = blk_a_q[BYTE_OFFSET+INDEX-1:BYTE_OFFSET];
        wr_tag   = blk_a_q[AWIDTH-1:BYTE_OFFSET+INDEX];
        if (mem_ready) begin
          wren_c  = 1'b1;
          state_d = (mis_q && !hit_b_lat) ? REFILL_B : IDLE;
        end
      end
      REFILL_B: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = blk_b_q;
        index_sel = 1'b1;
        wr_idx    = idx_b_q;
        wr_tag    = blk_b_q[AWIDTH-1:BYTE_OFFSET+INDEX];
        if (mem_ready) begin
          wren_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A write landing in the reset cycle must not leave a stale tag marked valid.
  assign wren   = wren_c & ~rst;
  assign tag_we = wren;

  assign fence_pending_d = fence_i | (fence_pending_q & ~clr_all);
  assign blk_a_d = latch_en ? blk_a      : blk_a_q;
  assign blk_b_d = latch_en ? blk_b      : blk_b_q;
  assign idx_b_d = latch_en ? idx_b      : idx_b_q;
  assign mis_d   = latch_en ? misaligned : mis_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      fence_pending_q <= 1'b0;
      blk_a_q         <= '0;
      blk_b_q         <= '0;
      idx_b_q         <= '0;
      mis_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      fence_pending_q <= fence_pending_d;
      blk_a_q         <= blk_a_d;
      blk_b_q         <= blk_b_d;
      idx_b_q         <= idx_b_d;
      mis_q           <= mis_d;
      if (clr_all) begin
        valid_q <= '0;
      end else if (tag_we) begin
        valid_q[wr_idx] <= 1'b1;
      end
    end
  end

  // Tags need no reset: every entry is qualified by its valid bit.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q[wr_idx] <= wr_tag;
    end
  end

  assign index            = idx_a;
  assign index_missallign = idx_b;
  assign data_in          = mem_data;

endmodule

// File: tb/tb_riscv_icache_refill.sv
// Self-checking bench for riscv_icache_refill: directed scenarios plus randomized fetches
// compared against a block-residency model (index -> resident block number).
module tb_riscv_icache_refill;

  logic         clk;
  logic         rst;
  logic         cpu_req;
  logic [63:0]  cpu_addr;
  logic         fence_i;
  logic         stall;
  logic         mem_req;
  logic [63:0]  mem_addr;
  logic         mem_ready;
  logic [127:0] mem_data;
  logic         wren;
  logic         index_sel;
  logic [11:0]  index;
  logic [11:0]  index_missallign;
  logic [127:0] data_in;

  int checks = 0;
  int errors = 0;

  // Model: which block number currently occupies each cache index.
  longint unsigned res [int unsigned];

  riscv_icache_refill dut (
    .clk              (clk),
    .rst              (rst),
    .cpu_req          (cpu_req),
    .cpu_addr         (cpu_addr),
    .fence_i          (fence_i),
    .stall            (stall),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ready        (mem_ready),
    .mem_data         (mem_data),
    .wren             (wren),
    .index_sel        (index_sel),
    .index            (index),
    .index_missallign (index_missallign),
    .data_in          (data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit model_hit(input int unsigned idx, input longint unsigned blk);
    return res.exists(idx) && (res[idx] == blk);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cpu_req = 1'b0; fence_i = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    res.delete();
  endtask

  // Issues one fetch and walks the refill sequence the model predicts.
  task automatic run_fetch(input string nm, input logic [63:0] addr, input int lat);
    longint unsigned blk_a, blk_b, q_blk[$];
    int unsigned ia, ib;
    bit mis, q_sel[$];
    blk_a = addr >> 4;
    blk_b = blk_a + 1;
    ia = int'(blk_a % 4096);
    ib = int'(blk_b % 4096);
    mis = (addr % 16) > 12;
    if (!model_hit(ia, blk_a)) begin q_blk.push_back(blk_a); q_sel.push_back(1'b0); end
    if (mis && !model_hit(ib, blk_b)) begin q_blk.push_back(blk_b); q_sel.push_back(1'b1); end
    cpu_req = 1'b1; cpu_addr = addr;
    #1;
    checks++;
    if (stall !== (q_blk.size() != 0)) begin errors++;
      $display("FAIL %s lookup stall: got %0b exp %0b", nm, stall, q_blk.size() != 0); end
    checks++;
    if (mem_req !== 1'b0 || wren !== 1'b0) begin errors++;
      $display("FAIL %s idle mem_req/wren: got %0b/%0b exp 0/0", nm, mem_req, wren); end
    checks++;
    if (index !== 12'(ia) || index_missallign !== 12'(ib)) begin errors++;
      $display("FAIL %s index: got %h/%h exp %h/%h", nm, index, index_missallign, ia, ib); end
    for (int r = 0; r < q_blk.size(); r++) begin
      @(negedge clk);
      for (int k = 0; k < lat; k++) begin
        mem_ready = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1 || mem_req !== 1'b1 || wren !== 1'b0 || mem_addr !== 64'(q_blk[r] << 4)) begin
          errors++;
          $display("FAIL %s wait: stall=%0b mem_req=%0b wren=%0b mem_addr=%h exp 1/1/0/%h",
                   nm, stall, mem_req, wren, mem_addr, 64'(q_blk[r] << 4));
        end
        @(negedge clk);
      end
      mem_ready = 1'b1;
      mem_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      #1;
      checks++;
      if (wren !== 1'b1 || index_sel !== q_sel[r] || mem_addr !== 64'(q_blk[r] << 4)) begin
        errors++;
        $display("FAIL %s write: wren=%0b sel=%0b mem_addr=%h exp 1/%0b/%h",
                 nm, wren, index_sel, mem_addr, q_sel[r], 64'(q_blk[r] << 4));
      end
      checks++;
      if (data_in !== mem_data || index_missallign !== 12'(ib)) begin errors++;
        $display("FAIL %s data_in/index_missallign: got %h/%h exp %h/%h",
                 nm, data_in, index_missallign, mem_data, ib); end
      res[int'(q_blk[r] % 4096)] = q_blk[r];
    end
    if (q_blk.size() != 0) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0 || mem_req !== 1'b0) begin errors++;
        $display("FAIL %s relookup: stall=%0b mem_req=%0b exp 0/0", nm, stall, mem_req); end
    end
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cpu_addr = 64'h1000;
    #1;
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || wren !== 1'b0) begin errors++;
      $display("FAIL reset: stall=%0b mem_req=%0b wren=%0b exp 0/0/0", stall, mem_req, wren); end
  endtask

  task automatic test_single_miss();
    run_fetch("miss_1000", 64'h1000, 3);
    run_fetch("hit_1000", 64'h1000, 0);
  endtask

  task automatic test_hit_same_block();
    run_fetch("fill_3000", 64'h3000, 1);
    run_fetch("hit_3004", 64'h3004, 2);
    run_fetch("aligned_300C", 64'h300C, 0);
  endtask

  task automatic test_misaligned();
    do_reset();
    run_fetch("mis_200E", 64'h200E, 2);
    run_fetch("mis_200E_hit", 64'h200E, 0);
  endtask

  task automatic test_wrap();
    run_fetch("fill_FFF0", 64'hFFF0, 1);
    run_fetch("wrap_FFFD", 64'hFFFD, 2);
    run_fetch("hit_10000", 64'h10000, 0);
  endtask

  task automatic test_fence();
    do_reset();
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 64'h1000;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL fence cold stall: got %0b exp 1", stall); end
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h1000) begin errors++;
      $display("FAIL fence refill: mem_req=%0b mem_addr=%h exp 1/1000", mem_req, mem_addr); end
    fence_i = 1'b1;
    @(negedge clk);
    fence_i = 1'b0; mem_ready = 1'b1;
    #1;
    checks++;
    if (wren !== 1'b1 || index_sel !== 1'b0) begin errors++;
      $display("FAIL fence write: wren=%0b sel=%0b exp 1/0", wren, index_sel); end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1 || mem_req !== 1'b0 || wren !== 1'b0) begin errors++;
      $display("FAIL fence clear cycle: stall=%0b mem_req=%0b wren=%0b exp 1/0/0", stall, mem_req, wren); end
    res.delete();
    @(negedge clk);
    cpu_req = 1'b0;
    run_fetch("refetch_after_fence", 64'h1000, 1);
  endtask

  task automatic test_reset_mid_refill();
    run_fetch("fill_3000_pre", 64'h3000, 0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 64'h5000;
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h5000) begin errors++;
      $display("FAIL midreset refill: mem_req=%0b mem_addr=%h exp 1/5000", mem_req, mem_addr); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cpu_req = 1'b0;
    res.delete();
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin errors++;
      $display("FAIL midreset idle: mem_req=%0b stall=%0b exp 0/0", mem_req, stall); end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (wren !== 1'b0) begin errors++; $display("FAIL midreset late ready wren: got %0b exp 0", wren); end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL midreset stays idle: mem_req=%0b exp 0", mem_req); end
    run_fetch("3000_after_reset", 64'h3000, 1);
  endtask

  task automatic test_random();
    longint unsigned bases [4] = '{64'h400, 64'h1400, 64'hFFE, 64'h1FFE};
    longint unsigned blk;
    logic [63:0] a;
    for (int n = 0; n < 80; n++) begin
      blk = bases[$urandom_range(0, 3)] + longint'($urandom_range(0, 2));
      a = 64'(blk * 16 + longint'($urandom_range(0, 15)));
      run_fetch("random", a, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        cpu_addr = 64'($urandom());
        #1;
        checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0) begin errors++;
          $display("FAIL random idle: stall=%0b mem_req=%0b exp 0/0", stall, mem_req); end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; fence_i = 1'b0;
    mem_ready = 1'b0; mem_data = '0;
    test_reset();
    test_single_miss();
    test_hit_same_block();
    test_misaligned();
    test_wrap();
    test_fence();
    test_reset_mid_refill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_icache_refill.md
RISCV_ICACHE_REFILL -- requirements
Module: riscv_icache_refill

Interface
REQ-001 SHALL have parameter INDEX, default 12, meaning cache index width.
REQ-002 SHALL have parameter DWIDTH, default 128, meaning block width in bits.
REQ-003 SHALL have parameter AWIDTH, default 64, meaning fetch address width.
REQ-004 SHALL have parameter BYTE_OFFSET, default 4, meaning block byte-offset width; TAG = AWIDTH-INDEX-BYTE_OFFSET.
REQ-005 SHALL have parameter CACHE_DEPTH, default 4096, meaning number of blocks.
REQ-006 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-007 SHALL have rst  input  1  synchronous active-high reset.
REQ-008 SHALL have cpu_req  input  1  fetch valid.
REQ-009 SHALL have cpu_addr  input  AWIDTH  fetch byte address.
REQ-010 SHALL have fence_i  input  1  single-cycle invalidate-all request.
REQ-011 SHALL have stall  output  1  fetch not serviceable this cycle.
REQ-012 SHALL have mem_req  output  1  memory block read request.
REQ-013 SHALL have mem_addr  output  AWIDTH  block-aligned request address, low BYTE_OFFSET bits zero.
REQ-014 SHALL have mem_ready  input  1  mem_data valid this cycle.
REQ-015 SHALL have mem_data  input  DWIDTH  returned block.
REQ-016 SHALL have wren  output  1  data-array write enable.
REQ-017 SHALL have index_sel  output  1  0 = write at index, 1 = write at index_missallign.
REQ-018 SHALL have index  output  INDEX  cpu_addr[BYTE_OFFSET+INDEX-1:BYTE_OFFSET].
REQ-019 SHALL have index_missallign  output  INDEX  (index+1) mod CACHE_DEPTH.
REQ-020 SHALL have data_in  output  DWIDTH  equal to mem_data, combinational.

Function
REQ-021 SHALL hold internal tag array (CACHE_DEPTH x TAG) and valid vector (CACHE_DEPTH bits); block A = cpu_addr's block, block B = block A address + 2^BYTE_OFFSET (tag from incremented address; index wraps CACHE_DEPTH-1 -> 0).
REQ-022 SHALL treat a fetch as misaligned when cpu_addr[BYTE_OFFSET-1:0] > 12; only then is block B required.
REQ-023 SHALL have FSM states IDLE, REFILL_A, REFILL_B.
REQ-024 SHALL, in IDLE, compute hit_A = valid & tag match at index, hit_B likewise at index_missallign; stall = cpu_req & (miss_A | (misaligned & miss_B)) | fence_pending, combinational.
REQ-025 SHALL transition IDLE -> REFILL_A on cpu_req & miss_A; IDLE -> REFILL_B on cpu_req & hit_A & misaligned & miss_B.
REQ-026 SHALL, in REFILL_A/REFILL_B, drive stall=1, mem_req=1, mem_addr = block A/B address, held stable until mem_ready.
REQ-027 SHALL, in the cycle mem_ready=1, assert wren=1 with index_sel=0 (REFILL_A) or 1 (REFILL_B), and at that rising edge write tag and set valid for that index.
REQ-028 SHALL on mem_ready leave REFILL_A for REFILL_B if misaligned and block B not hit, else IDLE; leave REFILL_B for IDLE.
REQ-029 SHALL keep wren=0 outside mem_ready cycles of refill states; mem_req=0 in IDLE.
REQ-030 SHALL sample cpu_addr only in IDLE; cpu_addr is required stable while stall=1.
REQ-031 SHALL latch fence_i into fence_pending in any state; in IDLE with fence_pending=1, clear all valid bits and fence_pending at that edge, stall=1 that cycle, no refill started.
REQ-032 SHALL, for index = CACHE_DEPTH-1 misaligned fetch, use index_missallign = 0 and block B tag from carried address.
REQ-033 SHALL produce hit one cycle after the last refill write (re-lookup in IDLE), so data-array negedge read returns written data.

Reset
REQ-034 SHALL on rst (any state, including mid-refill): state=IDLE, all valid=0, fence_pending=0, mem_req=0, wren=0; stall then follows REQ-024.
REQ-035 SHALL ignore a mem_ready arriving after a mid-refill reset.

Verification
REQ-036 SHALL test: reset, cpu_req=1, cpu_addr=0x1000 -> stall=1, mem_req=1, mem_addr=0x1000; mem_ready after 3 cycles -> wren=1, index_sel=0, index=0x100; next cycle stall=0.
REQ-037 SHALL test: cpu_addr=0x200E, both blocks cold -> refill 0x2000 (index_sel=0) then 0x2010 (index_sel=1, index_missallign=0x201), then stall=0.
REQ-038 SHALL test: cpu_addr=0xFFFD (index 0xFFF) block A resident -> single refill mem_addr=0x10000, index_missallign=0, index_sel=1.
REQ-039 SHALL test: fence_i pulse during REFILL_A -> refill completes, then one stall cycle clearing valids; re-fetch of 0x1000 misses.
REQ-040 SHALL test: rst asserted while mem_req=1 -> next cycle mem_req=0, IDLE; late mem_ready -> wren stays 0.
REQ-041 SHALL test: cpu_addr=0x3004 after 0x3000 refilled -> stall=0, no mem_req.
